// File: rtl/uart_tx_arbiter_pkg.sv
// Shared configuration for the UART transmit arbiter.
// Holds the FSM encoding, default busy timeout and baud divider.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_t;

    localparam int BUSY_TIMEOUT_DEF = 4;
    localparam int CFG_DIVIDER      = 434;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or
// after the start index, wrapping, as one-hot, index and valid.
module uart_tx_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_j;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_j     = '0;
        for (int k = 0; k < N; k++) begin
            // Modulo-N wrap without a divider
            w_sum = {1'b0, i_start} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_j = w_sum[IW-1:0];
            if (!o_valid && i_req[w_j]) begin
                o_valid    = 1'b1;
                o_idx      = w_j;
                o_gnt[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one buart transmitter between N_REQ byte requesters with
// round-robin arbitration, per-owner lock and a busy-rise watchdog.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_data,
    input  logic [N_REQ-1:0]           req_lock,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       uart_wr,
    output logic [7:0]                 uart_tx_data,
    input  logic                       uart_busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       active,
    output logic                       timeout_err
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic [CW-1:0]    r_cnt;
    logic             r_own;
    logic             r_wr;
    logic [N_REQ-1:0] r_ready;
    logic [7:0]       r_data;
    logic [IW-1:0]    r_gid;
    logic             r_active;
    logic             r_terr;

    logic [CW-1:0]    w_cnt_nxt;
    logic             w_own_nxt;
    logic             w_wr_nxt;
    logic [N_REQ-1:0] w_ready_nxt;
    logic [7:0]       w_data_nxt;
    logic [IW-1:0]    w_gid_nxt;
    logic             w_active_nxt;
    logic             w_terr_nxt;

    logic [IW-1:0]    w_start;
    logic [N_REQ-1:0] w_owner_mask;
    logic             w_lock_hold;
    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_gnt;
    logic [IW-1:0]    w_idx;
    logic             w_win_vld;
    logic             w_grant;
    logic             w_cnt_last;

    assign w_start      = (r_gid == IW'(N_REQ-1)) ? '0 : r_gid + IW'(1);
    assign w_owner_mask = N_REQ'(1) << r_gid;
    // Only the last owner's lock matters; locks on others are ignored
    assign w_lock_hold  = r_own & req_lock[r_gid];
    assign w_elig       = w_lock_hold ? (req_valid & w_owner_mask)
                                      : req_valid;
    assign w_grant      = (r_state == ST_IDLE) & ~uart_busy & w_win_vld;
    assign w_cnt_last   = (r_cnt == CW'(BUSY_TIMEOUT-1));

    uart_tx_arbiter_rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .i_req   (w_elig),
        .i_start (w_start),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_win_vld)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (uart_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (w_cnt_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_wr_nxt     = w_grant;
        w_ready_nxt  = w_grant ? w_gnt : '0;
        w_data_nxt   = r_data;
        w_gid_nxt    = r_gid;
        w_own_nxt    = r_own;
        w_cnt_nxt    = '0;
        w_terr_nxt   = r_terr;
        w_active_nxt = (w_state_nxt != ST_IDLE);
        if (w_grant) begin
            w_data_nxt = req_data[{w_idx, 3'b000} +: 8];
            w_gid_nxt  = w_idx;
            w_own_nxt  = 1'b1;
        end
        if (r_state == ST_WAIT_BUSY && !uart_busy) begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (w_cnt_last) begin
                w_terr_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_own    <= 1'b0;
            r_wr     <= 1'b0;
            r_ready  <= '0;
            r_data   <= 8'h00;
            r_gid    <= IW'(N_REQ-1);
            r_active <= 1'b0;
            r_terr   <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_own    <= w_own_nxt;
            r_wr     <= w_wr_nxt;
            r_ready  <= w_ready_nxt;
            r_data   <= w_data_nxt;
            r_gid    <= w_gid_nxt;
            r_active <= w_active_nxt;
            r_terr   <= w_terr_nxt;
        end
    end

    assign uart_wr      = r_wr;
    assign req_ready    = r_ready;
    assign uart_tx_data = r_data;
    assign grant_id     = r_gid;
    assign active       = r_active;
    assign timeout_err  = r_terr;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one buart transmitter; legal range 2..8.
REQ-002 Parameter BUSY_TIMEOUT, default 4: max cycles after uart_wr for uart_busy to rise.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  N_REQ  per-requester byte pending; held until accepted.
REQ-006 req_data  input  8*N_REQ  byte of requester i in bits [8i+7:8i].
REQ-007 req_lock  input  N_REQ  requester i keeps exclusive ownership across bytes while high.
REQ-008 req_ready  output  N_REQ  one-cycle accept pulse, one-hot or zero.
REQ-009 uart_wr  output  1  write strobe to buart wr.
REQ-010 uart_tx_data  output  8  byte to buart tx_data.
REQ-011 uart_busy  input  1  from buart busy.
REQ-012 grant_id  output  clog2(N_REQ)  index of current/last owner.
REQ-013 active  output  1  high while a byte is in flight (any state except IDLE).
REQ-014 timeout_err  output  1  sticky flag; uart_busy failed to rise within BUSY_TIMEOUT.

Function
REQ-015 FSM states: IDLE, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-016 IDLE: with uart_busy low and an eligible req_valid, the arbiter selects a winner, drives uart_wr=1, uart_tx_data=winner byte, req_ready[winner]=1 for exactly the next cycle, loads grant_id, then enters WAIT_BUSY.
REQ-017 Latency: req_valid sampled high at edge k (IDLE, busy low) -> uart_wr and req_ready high during cycle k+1.
REQ-018 No grant issued in IDLE while uart_busy is high (covers buart post-reset dummy frame).
REQ-019 Round-robin: search starts at grant_id+1 modulo N_REQ, wrapping; after reset, search starts at index 0.
REQ-020 Lock: if req_lock[grant_id] is high on return to IDLE, only requester grant_id is eligible until its req_lock drops, even with its req_valid low.
REQ-021 Lock drop and another request on the same cycle: normal round-robin applies that cycle.
REQ-022 Lock on a non-owner is ignored until that requester wins a grant.
REQ-023 WAIT_BUSY: uart_busy high -> WAIT_DONE; otherwise after BUSY_TIMEOUT cycles -> IDLE and timeout_err set.
REQ-024 WAIT_DONE: uart_busy low -> IDLE; the next grant no earlier than the following cycle.
REQ-025 req_valid deassert before req_ready is permitted; that requester is simply not granted.
REQ-026 req_data changes while req_valid is high and unaccepted: the byte sampled at the grant edge is sent.
REQ-027 uart_wr never asserted outside IDLE exit; at most one uart_wr per frame.
REQ-028 timeout_err clears only on reset.

Reset
REQ-029 reset forces IDLE, uart_wr=0, req_ready=0, uart_tx_data=8'h00, grant_id=N_REQ-1 (so first search starts at 0), active=0, timeout_err=0, lock ownership cleared.
REQ-030 Reset asserted mid-frame aborts immediately; no req_ready is issued for the aborted byte beyond the one already pulsed.

Structure
REQ-031 FSM state encoding and BUSY_TIMEOUT default live in the shared config include alongside cfg_divider.
REQ-032 One sub-module, rr_pick: combinational round-robin priority selector (request vector, start index -> one-hot winner, valid).

Verification
REQ-033 After reset, buart busy high 15 bit-times; req_valid[2]=1, data 8'h41 -> no uart_wr until busy falls, then uart_wr one cycle with 8'h41, req_ready=4'b0100.
REQ-034 All four valid, data 8'h10..8'h13, no lock -> uart_tx_data sequence 10,11,12,13, grant_id 0,1,2,3, one byte per frame.
REQ-035 Requester 1 lock=1, sends 3 bytes 8'hA0..8'hA2 while requesters 0,3 valid -> A0,A1,A2 consecutive; lock drops -> next grant to 3, then 0.
REQ-036 uart_busy tied low -> after uart_wr, FSM returns to IDLE after 4 cycles, timeout_err=1 and stays 1.
REQ-037 reset pulsed during WAIT_DONE -> all outputs at reset values same cycle, grant search restarts at 0.
REQ-038 req_valid[1] withdrawn one cycle before grant edge -> requester 1 skipped, next valid requester granted.
